// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with a per-register pending-write scoreboard.
// Latency: reads, bypass and busy flags are combinational; storage and busy bits update on the falling clk edge.
// Backpressure: none; the datapath stalls issue itself when busyA/busyB report a pending producer.
//
// Ports:
//   clk, rst          falling-edge clock, asynchronous active-high reset
//   RegWr, Rw, busW   writeback port (also clears the busy bit of Rw)
//   Ra/busA, Rb/busB  combinational read ports
//   Issue, Rd         issue port, marks Rd as having a write pending
//   busyA, busyB      pending-write flags for Ra/Rb; anyBusy is the OR of all busy bits
module regfile_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWr,
    input  logic [ADDR_WIDTH-1:0] Rw,
    input  logic [DATA_WIDTH-1:0] busW,
    input  logic [ADDR_WIDTH-1:0] Ra,
    input  logic [ADDR_WIDTH-1:0] Rb,
    output logic [DATA_WIDTH-1:0] busA,
    output logic [DATA_WIDTH-1:0] busB,
    input  logic                  Issue,
    input  logic [ADDR_WIDTH-1:0] Rd,
    output logic                  busyA,
    output logic                  busyB,
    output logic                  anyBusy
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;

    // An address is writable when it decodes to a real register and is not
    // the hardwired zero register. Comparison is done at full width so that
    // out-of-range addresses never alias onto low registers.
    logic wr_ok;
    logic iss_ok;
    logic byp_a;
    logic byp_b;

    assign wr_ok  = RegWr && (32'(Rw) < 32'(NUM_REGS)) && !(ZERO_REG && (Rw == '0));
    assign iss_ok = Issue && (32'(Rd) < 32'(NUM_REGS)) && !(ZERO_REG && (Rd == '0));

    // Forwarding only applies to writes that would actually land in storage.
    assign byp_a = BYPASS && wr_ok && (Ra == Rw);
    assign byp_b = BYPASS && wr_ok && (Rb == Rw);

    // Next state: write data and busy bits. The issue set is applied after
    // the writeback clear so a same-register collision leaves the new
    // producer outstanding.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_ok && (32'(Rw) == 32'(i))) begin
                regs_d[i] = busW;
                busy_d[i] = 1'b0;
            end
            if (iss_ok && (32'(Rd) == 32'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Read decode: out-of-range addresses match no register and read 0.
    // Register 0 under ZERO_REG is never written or set busy, so its stored
    // value and busy bit stay at their reset value of 0.
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;
    logic                  bsy_a;
    logic                  bsy_b;

    always_comb begin
        rd_a  = '0;
        rd_b  = '0;
        bsy_a = 1'b0;
        bsy_b = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(Ra) == 32'(i)) begin
                rd_a  = regs_q[i];
                bsy_a = busy_q[i];
            end
            if (32'(Rb) == 32'(i)) begin
                rd_b  = regs_q[i];
                bsy_b = busy_q[i];
            end
        end
    end

    // While rst is high the bypass path must not leak busW onto the outputs.
    always_comb begin
        busA    = '0;
        busB    = '0;
        busyA   = 1'b0;
        busyB   = 1'b0;
        anyBusy = 1'b0;
        if (!rst) begin
            busA    = byp_a ? busW : rd_a;
            busB    = byp_b ? busW : rd_b;
            busyA   = bsy_a && !byp_a;
            busyB   = bsy_b && !byp_b;
            anyBusy = |busy_q;
        end
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the CPU's 32x32 register file.
- Generalises data width, register count and address width.
- Adds asynchronous clear, optional hardwired-zero register 0 and optional write-to-read bypass.
- Adds a per-register pending-write scoreboard, so a pipelined datapath can detect RAW hazards.
- Sits between decode (read/issue) and writeback (write).

Parameters:
DATA_WIDTH, 32, width of each register and of busW/busA/busB
NUM_REGS, 32, number of architectural registers (2..2^ADDR_WIDTH)
ADDR_WIDTH, 5, width of Ra/Rb/Rw/Rd
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy
BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
clk  in  1  clock; storage and scoreboard update on the falling edge
rst  in  1  asynchronous, active-high reset
RegWr  in  1  write enable (writeback stage)
Rw  in  ADDR_WIDTH  write address
busW  in  DATA_WIDTH  write data
Ra  in  ADDR_WIDTH  read address A
Rb  in  ADDR_WIDTH  read address B
busA  out  DATA_WIDTH  read data A
busB  out  DATA_WIDTH  read data B
Issue  in  1  instruction issued that will write register Rd
Rd  in  ADDR_WIDTH  destination of issued instruction
busyA  out  1  register Ra has a write pending
busyB  out  1  register Rb has a write pending
anyBusy  out  1  OR of all busy bits

Behaviour:
- Reset:
  - rst high asynchronously clears all registers to 0 and all busy bits to 0, regardless of clk.
  - While rst is high: busA=busB=0, busyA=busyB=anyBusy=0, and RegWr/Issue are ignored.
  - Deasserting rst mid-cycle causes no update until the next falling edge.
- Storage:
  - NUM_REGS x DATA_WIDTH flops.
  - On a falling clk edge with RegWr=1: reg[Rw] <= busW.
  - Registers not addressed hold their value.
- Reads: combinational, zero latency.
  - busA = reg[Ra], busB = reg[Rb].
  - Address >= NUM_REGS reads 0; a write to it is ignored.
- ZERO_REG=1:
  - Reg 0 always reads 0; writes to it are discarded.
  - Its busy bit is constant 0; Issue with Rd=0 has no effect.
- BYPASS=1:
  - While RegWr=1, a port whose address equals Rw (valid, not zero-reg) outputs busW instead of the stored value.
  - BYPASS=0: stored value only until the falling edge.
- Scoreboard: one busy bit per register, updated on the falling clk edge.
  - Issue=1 sets busy[Rd].
  - RegWr=1 clears busy[Rw].
  - Issue and RegWr to the same register in the same cycle: set wins (the new producer is outstanding).
  - Different registers: both take effect.
  - Issue to an already-busy register: stays busy (single-outstanding model; the clear at writeback releases it).
- Busy outputs:
  - busyA = busy[Ra], busyB = busy[Rb], combinational; anyBusy = OR of all busy bits.
  - With BYPASS=1 and RegWr=1, Rw==Ra: busyA=0 in that cycle (data forwarded). Same rule for B.
- Width: no arithmetic; out-of-range addresses are decoded, never truncated to alias.

Test Plan:
1. Reset then read all addresses -> busA=busB=0, anyBusy=0; assert rst mid-cycle after writing reg5=0xDEADBEEF -> busA (Ra=5) drops to 0 immediately, without waiting for a clock edge.
2. RegWr=1, Rw=7, busW=0x12345678, Ra=7, Rb=7, BYPASS=1 -> busA=busB=0x12345678 before the falling edge; after the edge with RegWr=0 it reads 0x12345678 stored. Repeat with BYPASS=0 -> old value 0 before the edge.
3. Write 0xFFFFFFFF to Rw=0 with ZERO_REG=1 -> busA (Ra=0) stays 0; Issue Rd=0 -> busyA stays 0, anyBusy stays 0.
4. Issue Rd=3 -> after the falling edge busyA (Ra=3)=1, anyBusy=1; a later RegWr Rw=3 busW=0xA5 -> busyA=0 during that cycle (bypass), busA=0xA5; after the edge anyBusy=0.
5. Same cycle Issue Rd=9 and RegWr Rw=9 busW=0x55 -> after the edge reg9=0x55 and busy[9]=1. Same cycle Issue Rd=4 and RegWr Rw=9 (busy[9] set) -> busy[4]=1, busy[9]=0.
6. NUM_REGS=24, ADDR_WIDTH=5: write 0x77 to Rw=30 -> ignored; Ra=30 reads 0; Ra=14 (aliased low bits) is unchanged.
